systolic_input_loader: RTL and testbench

- Parametrised operand loader for the N x N systolic MAC array.
- Accepts one A-row plus one B-column per ready/valid beat and buffers a full N x N tile of each matrix.
- Replays the tile into the array as diagonally skewed per-lane element streams, with back-pressure.
- Replaces the fixed 4x4, 8-bit, unskewed-register loader; adds skew generation, output stall and an abort path.

---
 rtl/systolic_input_loader.sv | 179 +++++++++++++++++
 tb/tb_systolic_input_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_loader.sv
// rtl/systolic_input_loader.sv - buffers an N x N A/B tile and replays it as skewed lane streams
module systolic_input_loader #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*N*DW-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  input  logic              feed_ready,
  output logic              feed_valid,
  output logic [N*DW-1:0]   a_feed,
  output logic [N*DW-1:0]   b_feed,
  output logic              load_done,
  output logic              feed_done
);

  localparam int BW = $clog2(N);
  localparam int TW = $clog2(2*N-1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N-1);
  localparam logic [TW-1:0] LAST_STEP = TW'(2*N-2);

  typedef enum logic {LOAD, FEED} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [TW-1:0]   t_q, t_d;
  logic            in_ready_q;
  logic            feed_valid_q, feed_valid_d;
  logic            load_done_q, load_done_d;
  logic            feed_done_q, feed_done_d;
  logic [N*DW-1:0] a_feed_q, b_feed_q;
  logic [N*DW-1:0] a_nxt, b_nxt;
  logic [TW-1:0]   next_t;
  logic            feed_load, feed_clr, wr_en;
  logic            beat_acc, feed_acc;

  // a_buf_q[r][k]: A row r element k; b_buf_q[k][c]: B column c element k
  logic [DW-1:0]   a_buf_q [N][N];
  logic [DW-1:0]   b_buf_q [N][N];

  assign beat_acc = in_valid && in_ready_q && (state_q == LOAD);
  assign feed_acc = feed_valid_q && feed_ready;

  // Next-state, counters and feed-register control; abort overrides any accept
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    t_d          = t_q;
    feed_valid_d = feed_valid_q;
    load_done_d  = 1'b0;
    feed_done_d  = 1'b0;
    next_t       = '0;
    feed_load    = 1'b0;
    feed_clr     = 1'b0;
    wr_en        = 1'b0;
    if (abort) begin
      state_d      = LOAD;
      beat_d       = '0;
      t_d          = '0;
      feed_valid_d = 1'b0;
      feed_clr     = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          feed_valid_d = 1'b0;
          if (beat_acc) begin
            wr_en = 1'b1;
            if (beat_q == LAST_BEAT) begin
              // Step 0 only reads row/column 0, already stored by beat 0
              beat_d       = '0;
              state_d      = FEED;
              t_d          = '0;
              load_done_d  = 1'b1;
              feed_valid_d = 1'b1;
              feed_load    = 1'b1;
              next_t       = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        FEED: begin
          feed_valid_d = 1'b1;
          if (feed_acc) begin
            if (t_q == LAST_STEP) begin
              state_d      = LOAD;
              t_d          = '0;
              feed_valid_d = 1'b0;
              feed_done_d  = 1'b1;
              feed_clr     = 1'b1;
            end else begin
              t_d       = t_q + 1'b1;
              next_t    = t_q + 1'b1;
              feed_load = 1'b1;
            end
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  // Skewed lane values for step next_t: lane i carries element next_t-i when in range
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(next_t) >= i) && (int'(next_t) - i < N)) begin
        a_nxt[i*DW +: DW] = a_buf_q[i][BW'(int'(next_t) - i)];
        b_nxt[i*DW +: DW] = b_buf_q[BW'(int'(next_t) - i)][i];
      end
    end
  end

  // Control state, counters, handshake and done pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      beat_q       <= '0;
      t_q          <= '0;
      in_ready_q   <= 1'b0;
      feed_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
      feed_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      t_q          <= t_d;
      in_ready_q   <= (state_d == LOAD);
      feed_valid_q <= feed_valid_d;
      load_done_q  <= load_done_d;
      feed_done_q  <= feed_done_d;
    end
  end

  // Registered feed outputs; held while the array stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_feed_q <= '0;
      b_feed_q <= '0;
    end else if (feed_clr) begin
      a_feed_q <= '0;
      b_feed_q <= '0;
    end else if (feed_load) begin
      a_feed_q <= a_nxt;
      b_feed_q <= b_nxt;
    end
  end

  // Tile storage: beat r writes A row r and B column r
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          a_buf_q[r][k] <= '0;
          b_buf_q[r][k] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        a_buf_q[beat_q][k] <= in_data[2*N*DW-1-k*DW -: DW];
        b_buf_q[k][beat_q] <= in_data[N*DW-1-k*DW -: DW];
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign feed_valid = feed_valid_q;
  assign a_feed     = a_feed_q;
  assign b_feed     = b_feed_q;
  assign load_done  = load_done_q;
  assign feed_done  = feed_done_q;

endmodule

// File: tb/tb_systolic_input_loader.sv
// tb/tb_systolic_input_loader.sv - scoreboard bench for systolic_input_loader (N=4/DW=8 and N=8/DW=16)
module tb_systolic_input_loader;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int N8  = 8;
  localparam int DW8 = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [2*N*DW-1:0] in_data = '0;
  logic in_valid = 1'b0, abort = 1'b0, feed_ready = 1'b1;
  logic in_ready, feed_valid, load_done, feed_done;
  logic [N*DW-1:0] a_feed, b_feed;

  logic [2*N8*DW8-1:0] in_data8 = '0;
  logic in_valid8 = 1'b0, abort8 = 1'b0, feed_ready8 = 1'b1;
  logic in_ready8, feed_valid8, load_done8, feed_done8;
  logic [N8*DW8-1:0] a_feed8, b_feed8;

  systolic_input_loader #(.N(N), .DW(DW)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .feed_ready(feed_ready), .feed_valid(feed_valid), .a_feed(a_feed),
    .b_feed(b_feed), .load_done(load_done), .feed_done(feed_done)
  );

  systolic_input_loader #(.N(N8), .DW(DW8)) u_dut8 (
    .clk(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .abort(abort8), .feed_ready(feed_ready8), .feed_valid(feed_valid8), .a_feed(a_feed8),
    .b_feed(b_feed8), .load_done(load_done8), .feed_done(feed_done8)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int ld_cnt = 0, fd_cnt = 0, exp_ld = 0, exp_fd = 0;
  int ld8_cnt = 0, fd8_cnt = 0;

  logic [DW-1:0]  ta  [N][N];
  logic [DW-1:0]  tbm [N][N];
  logic [DW8-1:0] ta8 [N8][N8];
  logic [DW8-1:0] tb8 [N8][N8];

  logic [2*N*DW-1:0]   q4[$];
  logic [2*N8*DW8-1:0] q8[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: compare every presented step, pop on accept
  always @(negedge clk) begin
    if (reset) begin
      if (feed_valid) begin
        if (q4.size() == 0) chk("feed4_unexpected", 1, 0);
        else begin
          chk("feed4_step", {a_feed, b_feed}, q4[0]);
          if (feed_ready && !abort) void'(q4.pop_front());
        end
      end
      if (feed_valid8) begin
        if (q8.size() == 0) chk("feed8_unexpected", 1, 0);
        else begin
          chk("feed8_step", {a_feed8, b_feed8}, q8[0]);
          if (feed_ready8 && !abort8) void'(q8.pop_front());
        end
      end
      if (load_done) ld_cnt++;
      if (feed_done) fd_cnt++;
      if (load_done8) ld8_cnt++;
      if (feed_done8) fd8_cnt++;
      if (load_done || feed_done) chk("done_exclusive", load_done && feed_done, 0);
    end
  end

  task automatic set_tile(input int seed);
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        if (seed == 0) begin
          ta[r][k]  = DW'(r*4 + k + 1);
          tbm[k][r] = DW'(16 + r*4 + k + 1);
        end else begin
          ta[r][k]  = DW'(seed*7 + r*16 + k*3 + 1);
          tbm[k][r] = DW'(seed*11 + k*16 + r*5 + 2);
        end
      end
  endtask

  task automatic push_tile4();
    logic [N*DW-1:0] ea, eb;
    for (int t = 0; t < 2*N-1; t++) begin
      ea = '0; eb = '0;
      for (int i = 0; i < N; i++)
        if (t >= i && t - i < N) begin
          ea[i*DW +: DW] = ta[i][t-i];
          eb[i*DW +: DW] = tbm[t-i][i];
        end
      q4.push_back({ea, eb});
    end
  endtask

  task automatic drive_beat4(input int r);
    for (int k = 0; k < N; k++) begin
      in_data[2*N*DW-1-k*DW -: DW] = ta[r][k];
      in_data[N*DW-1-k*DW -: DW]   = tbm[k][r];
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // Loads a whole tile; gap inserts an idle cycle after every beat
  task automatic load_tile(input int seed, input bit gap);
    set_tile(seed);
    push_tile4();
    wait_ready();
    for (int r = 0; r < N; r++) begin
      drive_beat4(r);
      in_valid = 1'b1;
      chk("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (r < N-1) begin
        chk("load_done_early", load_done, 0);
        if (gap) begin
          @(posedge clk); #1;
          chk("load_done_gap", load_done, 0);
        end
      end else begin
        chk("load_done_pulse", load_done, 1);
        chk("first_step_latency", feed_valid, 1);
        chk("in_ready_feed", in_ready, 0);
      end
    end
    exp_ld++;
  endtask

  // Drives feed_ready/abort through the feed phase; returns cycles spent
  task automatic run_feed(input int stall_at, input int stall_len, input int abort_at, output int cycles);
    int step, stalled;
    bit acc;
    step = 0; stalled = 0; cycles = 0;
    while (cycles < 100) begin
      abort = 1'b0;
      feed_ready = 1'b1;
      if (feed_valid && step == abort_at) abort = 1'b1;
      else if (feed_valid && step == stall_at && stalled < stall_len) begin
        feed_ready = 1'b0;
        stalled++;
      end
      acc = feed_valid && feed_ready && !abort;
      @(posedge clk); #1;
      cycles++;
      if (abort) begin
        abort = 1'b0;
        chk("abort_valid", feed_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_feed", {a_feed, b_feed}, 0);
        chk("abort_no_done", feed_done, 0);
        q4.delete();
        return;
      end
      if (acc) step++;
      if (step == 2*N-1) break;
    end
    chk("feed_steps", step, 2*N-1);
    chk("feed_done_pulse", feed_done, 1);
    chk("feed_end_valid", feed_valid, 0);
    chk("feed_end_ready", in_ready, 1);
    chk("feed_end_zero", {a_feed, b_feed}, 0);
    exp_fd++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    #12;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_feed_valid", feed_valid, 0);
    chk("reset_outputs", {a_feed, b_feed, load_done, feed_done}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: back-to-back beats, free-running array
    load_tile(0, 1'b0);
    run_feed(-1, 0, -1, cyc);
    chk("sc1_feed_cycles", cyc, 2*N-1);

    // 2: in_valid toggling during load
    load_tile(1, 1'b1);
    run_feed(-1, 0, -1, cyc);
    chk("sc2_feed_cycles", cyc, 2*N-1);

    // 3: three stall cycles at step 2
    load_tile(2, 1'b0);
    run_feed(2, 3, -1, cyc);
    chk("sc3_feed_cycles", cyc, 2*N-1+3);

    // 4: abort at step 4, then a clean tile
    load_tile(3, 1'b0);
    run_feed(-1, 0, 4, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_fd_count", fd_cnt, exp_fd);
    load_tile(4, 1'b0);
    run_feed(-1, 0, -1, cyc);
    chk("sc4_feed_cycles", cyc, 2*N-1);

    // 5: reset after two beats
    set_tile(5);
    wait_ready();
    for (int r = 0; r < 2; r++) begin
      drive_beat4(r);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset_in_ready", in_ready, 0);
    chk("midreset_outputs", {feed_valid, load_done, feed_done, a_feed, b_feed}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    load_tile(6, 1'b0);
    run_feed(-1, 0, -1, cyc);

    // 6: N=8, DW=16 instance with all-ones values on the diagonal
    for (int r = 0; r < N8; r++)
      for (int k = 0; k < N8; k++) begin
        ta8[r][k] = (r == k) ? 16'hFFFF : DW8'(r*256 + k + 1);
        tb8[k][r] = (k == 0 && r == 0) ? 16'hFFFF : DW8'(16'hF000 + k*16 + r + 1);
      end
    for (int t = 0; t < 2*N8-1; t++) begin
      logic [N8*DW8-1:0] ea, eb;
      ea = '0; eb = '0;
      for (int i = 0; i < N8; i++)
        if (t >= i && t - i < N8) begin
          ea[i*DW8 +: DW8] = ta8[i][t-i];
          eb[i*DW8 +: DW8] = tb8[t-i][i];
        end
      q8.push_back({ea, eb});
    end
    for (int k = 0; k < 20 && !in_ready8; k++) begin
      @(posedge clk); #1;
    end
    chk("n8_in_ready", in_ready8, 1);
    for (int r = 0; r < N8; r++) begin
      for (int k = 0; k < N8; k++) begin
        in_data8[2*N8*DW8-1-k*DW8 -: DW8] = ta8[r][k];
        in_data8[N8*DW8-1-k*DW8 -: DW8]   = tb8[k][r];
      end
      in_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    chk("n8_load_done", load_done8, 1);
    cyc = 0;
    while (cyc < 60 && !feed_done8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("n8_feed_cycles", cyc, 2*N8-1);

    @(posedge clk); #1;
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    chk("load_done_count", ld_cnt, exp_ld);
    chk("feed_done_count", fd_cnt, exp_fd);
    chk("n8_done_counts", {ld8_cnt[7:0], fd8_cnt[7:0]}, {8'd1, 8'd1});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
